// File: rtl/nnrv_mem_pkg.sv
// nnrv_mem_pkg: shared definitions for the nnrv memory stage.
//   - access size encodings (byte/half/word/dword)
//   - FSM state encoding of the stage
//   - lane_off_w(): width of the byte-lane offset inside one XLEN word
//   - eff_size(): maps a dword request onto a word when XLEN is 32
package nnrv_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  function automatic int lane_off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // A dword access on a 32-bit datapath is treated as a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int xlen);
    if ((size == SZ_DWORD) && (xlen == 32)) begin
      return SZ_WORD;
    end else begin
      return size;
    end
  endfunction

endpackage

// File: rtl/nnrv_mem_if.sv
// nnrv_mem_if: RAM request/response bus of the memory stage.
//   req/we/addr/be/wdata : request side, driven by the stage (master)
//   gnt                  : request accepted this cycle (slave)
//   rvalid/rdata         : read response, aligned word (slave)
interface nnrv_mem_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/nnrv_mem_align.sv
// nnrv_mem_align: combinational byte-lane steering for the memory stage.
//   Store side: i_st_off/i_st_size/i_st_data -> o_be (byte enables) and
//               o_wdata (store data shifted into its lanes). Lanes beyond
//               the word are dropped.
//   Load side : i_ld_off/i_ld_size/i_ld_sign/i_rdata -> o_ld_data, the
//               addressed bytes right-aligned and sign/zero extended.
//   Sizes arriving here are already effective sizes (never dword on XLEN=32).
module nnrv_mem_align
  import nnrv_mem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BW   = XLEN / 8,
  localparam int OFFW = lane_off_w(XLEN)
) (
  input  logic [OFFW-1:0] i_st_off,
  input  logic [1:0]      i_st_size,
  input  logic [XLEN-1:0] i_st_data,
  output logic [BW-1:0]   o_be,
  output logic [XLEN-1:0] o_wdata,
  input  logic [OFFW-1:0] i_ld_off,
  input  logic [1:0]      i_ld_size,
  input  logic            i_ld_sign,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [BW-1:0]   mask_s;
  logic [2*BW-1:0] be_wide_s;
  logic [XLEN-1:0] ld_shift_s;
  logic            ld_msb_s;
  int              ld_bits_s;

  // Store byte enables and lane-shifted store data.
  always_comb begin
    mask_s = {BW{1'b0}};
    for (int i = 0; i < BW; i++) begin
      mask_s[i] = (i < (32'sd1 <<< i_st_size));
    end
    // Shift in a double-width vector so lanes past the word fall off the top.
    be_wide_s = {{BW{1'b0}}, mask_s} << i_st_off;
    o_be      = be_wide_s[BW-1:0];
    o_wdata   = i_st_data << {i_st_off, 3'b000};
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    ld_shift_s = i_rdata >> {i_ld_off, 3'b000};
    ld_bits_s  = 32'sd8 <<< i_ld_size;
    case (i_ld_size)
      SZ_BYTE: ld_msb_s = ld_shift_s[7];
      SZ_HALF: ld_msb_s = ld_shift_s[15];
      SZ_WORD: ld_msb_s = ld_shift_s[31];
      default: ld_msb_s = ld_shift_s[XLEN-1];
    endcase
    o_ld_data = {XLEN{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      o_ld_data[i] = (i < ld_bits_s) ? ld_shift_s[i] : (i_ld_sign & ld_msb_s);
    end
  end

endmodule

// File: rtl/nnrv_mem_stage.sv
// nnrv_mem_stage: memory stage between exec and writeback.
//   One outstanding load/store over the req/gnt/rvalid RAM bus (ram, master
//   modport of nnrv_mem_if); non-memory ops pass to writeback in one cycle.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_exec_*                instruction from exec; o_exec_stall holds exec
//   ram                     RAM request/response bus
//   o_wb_rd_en/rd/rd_reg    registered writeback
//   o_id_rd_en/rd/ready/reg forwarding view of the register held in the stage
//   o_misalign              misaligned-access pulse (MEM_MISALIGN_TRAP_EN only)
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of issuing them with out-of-word lanes dropped.
module nnrv_mem_stage
  import nnrv_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_exec_valid,
  output logic              o_exec_stall,
  input  logic              i_exec_rd_en,
  input  logic [REG_AW-1:0] i_exec_rd,
  input  logic [XLEN-1:0]   i_exec_rd_reg,
  input  logic              i_exec_ld,
  input  logic              i_exec_st,
  input  logic [XLEN-1:0]   i_exec_addr,
  input  logic [XLEN-1:0]   i_exec_data,
  input  logic [1:0]        i_exec_size,
  input  logic              i_exec_sign,
  nnrv_mem_if.master        ram,
  output logic              o_wb_rd_en,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_rd_reg,
  output logic              o_id_rd_en,
  output logic [REG_AW-1:0] o_id_rd,
  output logic              o_id_rd_ready,
  output logic [XLEN-1:0]   o_id_rd_reg
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              o_misalign
`endif
);

  localparam int BW   = XLEN / 8;
  localparam int OFFW = lane_off_w(XLEN);

  mem_state_e        state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic [XLEN-1:0]   ram_addr_q, ram_addr_d;
  logic [BW-1:0]     ram_be_q, ram_be_d;
  logic [XLEN-1:0]   ram_wdata_q, ram_wdata_d;
  logic [OFFW-1:0]   ld_off_q, ld_off_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_sign_q, ld_sign_d;
  logic              wb_rd_en_q, wb_rd_en_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_rd_reg_q, wb_rd_reg_d;
  logic              id_rd_en_q, id_rd_en_d;
  logic [REG_AW-1:0] id_rd_q, id_rd_d;
  logic              id_rd_ready_q, id_rd_ready_d;
  logic [XLEN-1:0]   id_rd_reg_q, id_rd_reg_d;
  logic              misalign_q, misalign_d;

  logic [OFFW-1:0]   exec_off_s;
  logic [1:0]        exec_size_s;
  logic              is_mem_s;
  logic              trap_s;
  logic [BW-1:0]     al_be_s;
  logic [XLEN-1:0]   al_wdata_s;
  logic [XLEN-1:0]   ld_data_s;

  assign exec_off_s  = i_exec_addr[OFFW-1:0];
  assign exec_size_s = eff_size(i_exec_size, XLEN);
  assign is_mem_s    = i_exec_ld | i_exec_st;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [OFFW-1:0] mis_mask_s;
  assign mis_mask_s = OFFW'((32'd1 << exec_size_s) - 32'd1);
  assign trap_s     = |(exec_off_s & mis_mask_s);
  assign o_misalign = misalign_q;
`else
  assign trap_s     = 1'b0;
`endif

  nnrv_mem_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_st_off  (exec_off_s),
    .i_st_size (exec_size_s),
    .i_st_data (i_exec_data),
    .o_be      (al_be_s),
    .o_wdata   (al_wdata_s),
    .i_ld_off  (ld_off_q),
    .i_ld_size (ld_size_q),
    .i_ld_sign (ld_sign_q),
    .i_rdata   (ram.rdata),
    .o_ld_data (ld_data_s)
  );

  // Next-state and next-output logic of the stage FSM.
  always_comb begin
    state_d       = state_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_be_d      = ram_be_q;
    ram_wdata_d   = ram_wdata_q;
    ld_off_d      = ld_off_q;
    ld_size_d     = ld_size_q;
    ld_sign_d     = ld_sign_q;
    wb_rd_en_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_rd_reg_d   = wb_rd_reg_q;
    id_rd_en_d    = id_rd_en_q;
    id_rd_d       = id_rd_q;
    id_rd_ready_d = id_rd_ready_q;
    id_rd_reg_d   = id_rd_reg_q;
    misalign_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nothing is held unless a new instruction is taken this cycle.
        id_rd_en_d    = 1'b0;
        id_rd_ready_d = 1'b0;
        if (i_exec_valid && is_mem_s && trap_s) begin
          misalign_d = 1'b1;
        end else if (i_exec_valid && is_mem_s) begin
          state_d     = ST_REQ;
          ram_we_d    = i_exec_st;
          ram_addr_d  = {i_exec_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          ram_be_d    = al_be_s;
          ram_wdata_d = al_wdata_s;
          ld_off_d    = exec_off_s;
          ld_size_d   = exec_size_s;
          ld_sign_d   = i_exec_sign;
          id_rd_en_d  = i_exec_ld & i_exec_rd_en;
          id_rd_d     = i_exec_rd;
        end else if (i_exec_valid) begin
          wb_rd_en_d    = i_exec_rd_en && (i_exec_rd != {REG_AW{1'b0}});
          wb_rd_d       = i_exec_rd;
          wb_rd_reg_d   = i_exec_rd_reg;
          id_rd_en_d    = i_exec_rd_en;
          id_rd_d       = i_exec_rd;
          id_rd_ready_d = 1'b1;
          id_rd_reg_d   = i_exec_rd_reg;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ram.gnt) begin
          state_d = ram_we_q ? ST_IDLE : ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (ram.rvalid) begin
          state_d       = ST_IDLE;
          wb_rd_en_d    = id_rd_en_q && (id_rd_q != {REG_AW{1'b0}});
          wb_rd_d       = id_rd_q;
          wb_rd_reg_d   = ld_data_s;
          id_rd_ready_d = 1'b1;
          id_rd_reg_d   = ld_data_s;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= {XLEN{1'b0}};
      ram_be_q      <= {BW{1'b0}};
      ram_wdata_q   <= {XLEN{1'b0}};
      ld_off_q      <= {OFFW{1'b0}};
      ld_size_q     <= 2'd0;
      ld_sign_q     <= 1'b0;
      wb_rd_en_q    <= 1'b0;
      wb_rd_q       <= {REG_AW{1'b0}};
      wb_rd_reg_q   <= {XLEN{1'b0}};
      id_rd_en_q    <= 1'b0;
      id_rd_q       <= {REG_AW{1'b0}};
      id_rd_ready_q <= 1'b0;
      id_rd_reg_q   <= {XLEN{1'b0}};
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_be_q      <= ram_be_d;
      ram_wdata_q   <= ram_wdata_d;
      ld_off_q      <= ld_off_d;
      ld_size_q     <= ld_size_d;
      ld_sign_q     <= ld_sign_d;
      wb_rd_en_q    <= wb_rd_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_rd_reg_q   <= wb_rd_reg_d;
      id_rd_en_q    <= id_rd_en_d;
      id_rd_q       <= id_rd_d;
      id_rd_ready_q <= id_rd_ready_d;
      id_rd_reg_q   <= id_rd_reg_d;
      misalign_q    <= misalign_d;
    end
  end

  assign o_exec_stall  = (state_q != ST_IDLE);
  assign ram.req       = (state_q == ST_REQ);
  assign ram.we        = ram_we_q;
  assign ram.addr      = ram_addr_q;
  assign ram.be        = ram_be_q;
  assign ram.wdata     = ram_wdata_q;
  assign o_wb_rd_en    = wb_rd_en_q;
  assign o_wb_rd       = wb_rd_q;
  assign o_wb_rd_reg   = wb_rd_reg_q;
  assign o_id_rd_en    = id_rd_en_q;
  assign o_id_rd       = id_rd_q;
  assign o_id_rd_ready = id_rd_ready_q;
  assign o_id_rd_reg   = id_rd_reg_q;

endmodule

// File: tb/tb_nnrv_mem_stage.sv
// tb_nnrv_mem_stage: self-checking bench for nnrv_mem_stage (XLEN=32).
// Directed cases plus randomized ALU/load/store traffic, each checked
// against a byte-arithmetic reference model. The bench plays the RAM.
module tb_nnrv_mem_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_exec_valid;
  logic              o_exec_stall;
  logic              i_exec_rd_en;
  logic [REG_AW-1:0] i_exec_rd;
  logic [XLEN-1:0]   i_exec_rd_reg;
  logic              i_exec_ld;
  logic              i_exec_st;
  logic [XLEN-1:0]   i_exec_addr;
  logic [XLEN-1:0]   i_exec_data;
  logic [1:0]        i_exec_size;
  logic              i_exec_sign;
  logic              o_wb_rd_en;
  logic [REG_AW-1:0] o_wb_rd;
  logic [XLEN-1:0]   o_wb_rd_reg;
  logic              o_id_rd_en;
  logic [REG_AW-1:0] o_id_rd;
  logic              o_id_rd_ready;
  logic [XLEN-1:0]   o_id_rd_reg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              o_misalign;
`endif

  nnrv_mem_if #(.XLEN(XLEN)) ram_if ();

  always #5 i_clk = ~i_clk;

  nnrv_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_exec_valid  (i_exec_valid),
    .o_exec_stall  (o_exec_stall),
    .i_exec_rd_en  (i_exec_rd_en),
    .i_exec_rd     (i_exec_rd),
    .i_exec_rd_reg (i_exec_rd_reg),
    .i_exec_ld     (i_exec_ld),
    .i_exec_st     (i_exec_st),
    .i_exec_addr   (i_exec_addr),
    .i_exec_data   (i_exec_data),
    .i_exec_size   (i_exec_size),
    .i_exec_sign   (i_exec_sign),
    .ram           (ram_if),
    .o_wb_rd_en    (o_wb_rd_en),
    .o_wb_rd       (o_wb_rd),
    .o_wb_rd_reg   (o_wb_rd_reg),
    .o_id_rd_en    (o_id_rd_en),
    .o_id_rd       (o_id_rd),
    .o_id_rd_ready (o_id_rd_ready),
    .o_id_rd_reg   (o_id_rd_reg)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_misalign    (o_misalign)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- reference model (plain byte arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd3) ? 4 : (1 << size);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] size);
    logic [63:0] v;
    v = ((64'd1 << nbytes(size)) - 64'd1) << addr[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] v;
    v = {32'd0, data} << (8 * addr[1:0]);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                         input logic sign, input logic [31:0] rdata);
    logic [63:0] v;
    logic [63:0] lim;
    int          nbits;
    nbits = 8 * nbytes(size);
    lim   = 64'd1 << nbits;
    v     = ({32'd0, rdata} >> (8 * addr[1:0])) & (lim - 64'd1);
    if (sign && (v >= (lim >> 1))) v = v | ~(lim - 64'd1);
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic exec_idle();
    i_exec_valid  = 1'b0;
    i_exec_ld     = 1'b0;
    i_exec_st     = 1'b0;
    i_exec_rd_en  = 1'b0;
  endtask

  task automatic run_alu(input logic rd_en, input logic [4:0] rd, input logic [31:0] val);
    check_val("alu_stall_pre", o_exec_stall, 1'b0);
    i_exec_valid = 1'b1; i_exec_ld = 1'b0; i_exec_st = 1'b0;
    i_exec_rd_en = rd_en; i_exec_rd = rd; i_exec_rd_reg = val;
    tick();
    exec_idle();
    check_val("alu_wb_en", o_wb_rd_en, rd_en && (rd != 5'd0));
    if (rd_en && (rd != 5'd0)) begin
      check_val("alu_wb_rd", o_wb_rd, rd);
      check_val("alu_wb_val", o_wb_rd_reg, val);
    end
    check_val("alu_id_ready", o_id_rd_ready, 1'b1);
    check_val("alu_id_val", o_id_rd_reg, val);
    check_val("alu_stall", o_exec_stall, 1'b0);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int gdly, input int rdly);
    logic [31:0] exp_v;
    exp_v = m_load(addr, size, sign, rdata);
    check_val("ld_stall_pre", o_exec_stall, 1'b0);
    i_exec_valid = 1'b1; i_exec_ld = 1'b1; i_exec_st = 1'b0; i_exec_rd_en = 1'b1;
    i_exec_rd = rd; i_exec_addr = addr; i_exec_size = size; i_exec_sign = sign;
    i_exec_data = $urandom; i_exec_rd_reg = $urandom;
    tick();
    exec_idle();
    for (int c = 0; c <= gdly; c++) begin
      check_val("ld_req", ram_if.req, 1'b1);
      check_val("ld_we", ram_if.we, 1'b0);
      check_val("ld_addr", ram_if.addr, addr & 32'hFFFF_FFFC);
      check_val("ld_be", ram_if.be, m_be(addr, size));
      check_val("ld_stall", o_exec_stall, 1'b1);
      check_val("ld_id_en", o_id_rd_en, 1'b1);
      check_val("ld_id_rd", o_id_rd, rd);
      check_val("ld_id_ready", o_id_rd_ready, 1'b0);
      ram_if.gnt    = (c == gdly);
      ram_if.rvalid = 1'($urandom_range(0, 1));   // must be ignored while requesting
      ram_if.rdata  = $urandom;
      tick();
    end
    ram_if.gnt = 1'b0; ram_if.rvalid = 1'b0;
    for (int c = 1; c < rdly; c++) begin
      check_val("ld_resp_req", ram_if.req, 1'b0);
      check_val("ld_resp_stall", o_exec_stall, 1'b1);
      check_val("ld_resp_wb", o_wb_rd_en, 1'b0);
      tick();
    end
    ram_if.rvalid = 1'b1; ram_if.rdata = rdata;
    tick();
    ram_if.rvalid = 1'b0; ram_if.rdata = $urandom;
    check_val("ld_wb_en", o_wb_rd_en, rd != 5'd0);
    check_val("ld_wb_rd", o_wb_rd, rd);
    check_val("ld_wb_val", o_wb_rd_reg, exp_v);
    check_val("ld_id_ready_wb", o_id_rd_ready, 1'b1);
    check_val("ld_id_val", o_id_rd_reg, exp_v);
    check_val("ld_done_stall", o_exec_stall, 1'b0);
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] data, input int gdly);
    check_val("st_stall_pre", o_exec_stall, 1'b0);
    i_exec_valid = 1'b1; i_exec_ld = 1'b0; i_exec_st = 1'b1; i_exec_rd_en = 1'b0;
    i_exec_addr = addr; i_exec_size = size; i_exec_data = data; i_exec_sign = 1'b0;
    tick();
    exec_idle();
    for (int c = 0; c <= gdly; c++) begin
      check_val("st_req", ram_if.req, 1'b1);
      check_val("st_we", ram_if.we, 1'b1);
      check_val("st_addr", ram_if.addr, addr & 32'hFFFF_FFFC);
      check_val("st_be", ram_if.be, m_be(addr, size));
      check_val("st_wdata", ram_if.wdata, m_wdata(addr, data));
      check_val("st_stall", o_exec_stall, 1'b1);
      check_val("st_id_en", o_id_rd_en, 1'b0);
      ram_if.gnt = (c == gdly);
      tick();
    end
    ram_if.gnt = 1'b0;
    check_val("st_done_req", ram_if.req, 1'b0);
    check_val("st_done_stall", o_exec_stall, 1'b0);
    check_val("st_wb_en", o_wb_rd_en, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    int          r_op;

    i_rst = 1'b1;
    exec_idle();
    i_exec_rd = 5'd0; i_exec_rd_reg = 32'd0; i_exec_addr = 32'd0;
    i_exec_data = 32'd0; i_exec_size = 2'd0; i_exec_sign = 1'b0;
    ram_if.gnt = 1'b0; ram_if.rvalid = 1'b0; ram_if.rdata = 32'd0;
    tick();
    tick();
    check_val("rst_req", ram_if.req, 1'b0);
    check_val("rst_stall", o_exec_stall, 1'b0);
    check_val("rst_wb_en", o_wb_rd_en, 1'b0);
    check_val("rst_wb_rd", o_wb_rd, 5'd0);
    check_val("rst_wb_val", o_wb_rd_reg, 32'd0);
    check_val("rst_id_en", o_id_rd_en, 1'b0);
    check_val("rst_id_ready", o_id_rd_ready, 1'b0);
    check_val("rst_addr", ram_if.addr, 32'd0);
    check_val("rst_be", ram_if.be, 4'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_val("rst_misalign", o_misalign, 1'b0);
`endif
    i_rst = 1'b0;

    // lb, sign-extending, rvalid two cycles after gnt
    run_load(32'h0000_0103, 2'd0, 1'b1, 5'd7, 32'h80FF_1234, 1, 2);
    check_val("lb_const", o_wb_rd_reg, 32'hFFFF_FF80);
    // lhu from upper half
    run_load(32'h0000_0102, 2'd1, 1'b0, 5'd8, 32'hBEEF_0000, 0, 1);
    check_val("lhu_const", o_wb_rd_reg, 32'h0000_BEEF);
    // sb with grant withheld for three cycles
    run_store(32'h0000_0201, 2'd0, 32'h0000_0012, 3);
    // store granted immediately
    run_store(32'h0000_0300, 2'd2, 32'hCAFE_F00D, 0);
    // ALU ops, including write to x0
    run_alu(1'b1, 5'd5, 32'h0000_0055);
    run_alu(1'b1, 5'd0, 32'h0000_0077);

    // reset while waiting for read data, then a late rvalid
    i_exec_valid = 1'b1; i_exec_ld = 1'b1; i_exec_rd_en = 1'b1; i_exec_rd = 5'd3;
    i_exec_addr = 32'h0000_0400; i_exec_size = 2'd2; i_exec_sign = 1'b0;
    tick();
    exec_idle();
    ram_if.gnt = 1'b1;
    tick();
    ram_if.gnt = 1'b0;
    check_val("rr_in_resp", o_exec_stall, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_val("rr_req", ram_if.req, 1'b0);
    check_val("rr_stall", o_exec_stall, 1'b0);
    check_val("rr_id_en", o_id_rd_en, 1'b0);
    ram_if.rvalid = 1'b1; ram_if.rdata = 32'h1234_5678;
    tick();
    ram_if.rvalid = 1'b0;
    check_val("rr_late_wb", o_wb_rd_en, 1'b0);
    check_val("rr_late_req", ram_if.req, 1'b0);
    run_alu(1'b1, 5'd9, 32'h0000_0ABC);

`ifdef MEM_MISALIGN_TRAP_EN
    // misaligned word load traps without a RAM request
    i_exec_valid = 1'b1; i_exec_ld = 1'b1; i_exec_rd_en = 1'b1; i_exec_rd = 5'd4;
    i_exec_addr = 32'h0000_0102; i_exec_size = 2'd2;
    tick();
    exec_idle();
    check_val("mis_pulse", o_misalign, 1'b1);
    check_val("mis_req", ram_if.req, 1'b0);
    check_val("mis_stall", o_exec_stall, 1'b0);
    check_val("mis_wb", o_wb_rd_en, 1'b0);
    tick();
    check_val("mis_pulse_end", o_misalign, 1'b0);
    check_val("mis_req2", ram_if.req, 1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r_op   = $urandom_range(0, 2);
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom & 32'h0000_FFFF;
`ifdef MEM_MISALIGN_TRAP_EN
      r_addr = r_addr & ~(32'(nbytes(r_size)) - 32'd1);
`endif
      case (r_op)
        0: run_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        1: run_load(r_addr, r_size, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        default: run_store(r_addr, r_size, $urandom, $urandom_range(0, 3));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
